// File: rtl/sdram_pkg.sv
// Shared widths and FSM encoding for the SDRAM write-burst path.
// Imported by the burst controller and its bus interface.
package sdram_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } wr_burst_st_e;

endpackage : sdram_pkg

// File: rtl/sdram_wr_burst_ctrl_if.sv
// FIFO-read and command-stage signals of the write-burst controller, bundled.
// master = the controller; slave = the FIFO / command-stage side.
interface sdram_wr_burst_ctrl_if
  import sdram_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int CNT_W = 8,
  parameter int LEN_W = 4
);

  logic [CNT_W-1:0] fifo_data_num_i;
  logic             fifo_rd_en_o;
  logic [DW-1:0]    fifo_rd_data_i;
  logic             wr_req_o;
  logic [AW-1:0]    wr_addr_o;
  logic [LEN_W-1:0] wr_len_o;
  logic             wr_ack_i;
  logic             wr_data_req_i;
  logic [DW-1:0]    wr_data_o;
  logic             wr_data_vld_o;

  modport master (
    input  fifo_data_num_i, fifo_rd_data_i, wr_ack_i, wr_data_req_i,
    output fifo_rd_en_o, wr_req_o, wr_addr_o, wr_len_o, wr_data_o, wr_data_vld_o
  );

  modport slave (
    output fifo_data_num_i, fifo_rd_data_i, wr_ack_i, wr_data_req_i,
    input  fifo_rd_en_o, wr_req_o, wr_addr_o, wr_len_o, wr_data_o, wr_data_vld_o
  );

endinterface : sdram_wr_burst_ctrl_if

// File: rtl/sdram_wr_burst_ctrl.sv
// Pops BURST_LEN-word bursts (or a flushed partial burst) from the write FIFO and
// hands them to the SDRAM command stage at wrapping addresses inside a window.
module sdram_wr_burst_ctrl
  import sdram_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 8,
  parameter int LEN_W     = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_enable_i,
  input  logic                  flush_i,
  input  logic [ADDR_W-1:0]     wr_base_addr_i,
  input  logic [ADDR_W-1:0]     wr_end_addr_i,
  output logic                  busy_o,
  output logic                  err_o,
  sdram_wr_burst_ctrl_if.master bus
);

  localparam logic [ADDR_W:0]  BURST_SPAN = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [LEN_W-1:0] BURST_CNT  = LEN_W'(BURST_LEN);

  wr_burst_st_e state, state_next;

  logic              addr_vld;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  remain;
  logic              data_vld;
  logic              flush_pend;
  logic              err;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   span;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  len_pick;
  logic              fifo_has_full;
  logic              fifo_nonempty;
  logic [ADDR_W:0]   next_addr_sum;
  logic              start_burst;
  logic              req;
  logic              rd_en;
  logic              req_bad;

  // Until the base has been captured after reset, the window start is used directly.
  assign cur_addr = addr_vld ? addr : wr_base_addr_i;

  // Words left before the window end; an address past the end reads as a huge span.
  assign span = {1'b0, wr_end_addr_i} - {1'b0, cur_addr} + (ADDR_W + 1)'(1);
  assign len_full = (span >= BURST_SPAN) ? BURST_CNT : span[LEN_W-1:0];

  assign fifo_has_full = bus.fifo_data_num_i >= CNT_W'(len_full);
  assign fifo_nonempty = bus.fifo_data_num_i != '0;
  assign len_pick      = fifo_has_full ? len_full : LEN_W'(bus.fifo_data_num_i);

  assign next_addr_sum = {1'b0, addr} + (ADDR_W + 1)'(len);

  // A data request is legal only while words of the current burst remain.
  assign req_bad = bus.wr_data_req_i && !((state == DATA) && (remain != '0));

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_next  = state;
    start_burst = 1'b0;
    req         = 1'b0;
    rd_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_enable_i && (fifo_has_full || (flush_pend && fifo_nonempty))) begin
          start_burst = 1'b1;
          state_next  = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (bus.wr_ack_i) begin
          state_next = DATA;
        end
      end
      DATA: begin
        rd_en = bus.wr_data_req_i && (remain != '0);
        // remain reaches zero only on a pop, so its last word is on wr_data_o now.
        if (remain == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      addr_vld   <= 1'b0;
      addr       <= '0;
      len        <= '0;
      remain     <= '0;
      data_vld   <= 1'b0;
      flush_pend <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (!addr_vld) begin
        addr_vld <= 1'b1;
        addr     <= wr_base_addr_i;
      end else if (state == DONE) begin
        addr <= (next_addr_sum > {1'b0, wr_end_addr_i}) ? wr_base_addr_i
                                                        : next_addr_sum[ADDR_W-1:0];
      end

      if (start_burst) begin
        len    <= len_pick;
        remain <= len_pick;
      end else if (rd_en) begin
        remain <= remain - LEN_W'(1);
      end

      data_vld <= rd_en;

      // A new flush pulse wins over the clear from a burst starting the same cycle.
      if (flush_i) begin
        flush_pend <= 1'b1;
      end else if (start_burst) begin
        flush_pend <= 1'b0;
      end

      if (req_bad) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en_o  = sys_rst_n && rd_en;
  assign bus.wr_req_o      = req;
  assign bus.wr_addr_o     = addr;
  assign bus.wr_len_o      = len;
  assign bus.wr_data_o     = data_vld ? bus.fifo_rd_data_i : '0;
  assign bus.wr_data_vld_o = data_vld;
  assign busy_o            = state != IDLE;
  assign err_o             = err;

endmodule : sdram_wr_burst_ctrl

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Self-checking bench: FIFO model plus a window/address/length reference model,
// driving command-stage handshakes with random delays and data-request gaps.
module tb_sdram_wr_burst_ctrl;
  import sdram_pkg::*;

  localparam int CNT_W     = 8;
  localparam int LEN_W     = 4;
  localparam int BURST_LEN = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_enable = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              busy;
  logic              err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sdram_wr_burst_ctrl_if #(.DW(DATA_W), .AW(ADDR_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  sdram_wr_burst_ctrl #(.CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .LEN_W(LEN_W)) dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .wr_enable_i    (wr_enable),
    .flush_i        (flush),
    .wr_base_addr_i (base_addr),
    .wr_end_addr_i  (end_addr),
    .busy_o         (busy),
    .err_o          (err),
    .bus            (bus)
  );

  // FIFO model: pops on fifo_rd_en_o, data one cycle later; pushes land at the next edge.
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] push_q[$];
  bit clear_fifo = 1'b0;
  int underflow = 0;

  always @(posedge clk) begin
    if (clear_fifo) begin
      fifo_q.delete();
      push_q.delete();
    end else begin
      if (bus.fifo_rd_en_o === 1'b1) begin
        if (fifo_q.size() == 0) underflow++;
        else bus.fifo_rd_data_i <= fifo_q.pop_front();
      end
      while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
    end
    bus.fifo_data_num_i <= CNT_W'(fifo_q.size());
  end

  // Reference model state
  longint m_addr, m_base, m_end;
  int fifo_cnt;
  bit err_model;
  logic [DATA_W-1:0] exp_words[$];

  function automatic int len_full();
    longint span = m_end - m_addr + 1;
    return (span < BURST_LEN) ? int'(span) : BURST_LEN;
  endfunction

  function automatic void advance(input int n);
    m_addr = (m_addr + n > m_end) ? m_base : m_addr + n;
    fifo_cnt -= n;
  endfunction

  task automatic push_words(input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DATA_W'($urandom);
      push_q.push_back(w);
      exp_words.push_back(w);
    end
    fifo_cnt += n;
  endtask

  task automatic do_reset(input longint b, input longint e);
    @(negedge clk);
    rst_n = 1'b0;
    wr_enable = 1'b0;
    flush = 1'b0;
    bus.wr_ack_i = 1'b0;
    bus.wr_data_req_i = 1'b0;
    base_addr = ADDR_W'(b);
    end_addr = ADDR_W'(e);
    clear_fifo = 1'b1;
    repeat (3) @(negedge clk);
    clear_fifo = 1'b0;
    exp_words.delete();
    fifo_cnt = 0;
    err_model = 1'b0;
    m_base = b;
    m_end = e;
    m_addr = b;
    rst_n = 1'b1;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int waited = 0;
    @(negedge clk);
    #1;
    while (bus.wr_req_o !== 1'b1 && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    total++;
    ok = (bus.wr_req_o === 1'b1);
    if (!ok) begin
      bad++;
      $display("FAIL req_timeout: wr_req_o=%b after %0d cycles, want 1", bus.wr_req_o, waited);
    end
  endtask

  // Command-stage model: accept one burst, then request exp_len words.
  task automatic serve_burst(input int ack_dly, input bit gapped, input int exp_len,
                             input bit extra_req);
    bit ok;
    bit cur, prev, pop_exp;
    int issued = 0;
    int waited = 0;
    logic [DATA_W-1:0] w;
    wait_req(ok);
    if (!ok) return;
    total++;
    if (bus.wr_addr_o !== ADDR_W'(m_addr)) begin
      bad++;
      $display("FAIL burst_addr: got %h want %h", bus.wr_addr_o, ADDR_W'(m_addr));
    end
    total++;
    if (bus.wr_len_o !== LEN_W'(exp_len)) begin
      bad++;
      $display("FAIL burst_len: got %0d want %0d", bus.wr_len_o, exp_len);
    end
    repeat (ack_dly) @(negedge clk);
    #1;
    total++;
    if (bus.wr_req_o !== 1'b1 || bus.wr_addr_o !== ADDR_W'(m_addr)) begin
      bad++;
      $display("FAIL req_hold: req=%b addr=%h want req=1 addr=%h", bus.wr_req_o,
               bus.wr_addr_o, ADDR_W'(m_addr));
    end
    bus.wr_ack_i = 1'b1;
    @(negedge clk);
    bus.wr_ack_i = 1'b0;
    #1;
    total++;
    if (bus.wr_req_o !== 1'b0) begin
      bad++;
      $display("FAIL req_drop: wr_req_o=%b want 0", bus.wr_req_o);
    end
    prev = 1'b0;
    for (int cyc = 0; cyc < 200 && (issued < exp_len || prev); cyc++) begin
      @(negedge clk);
      if (issued < exp_len) cur = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      else cur = extra_req;
      pop_exp = cur && (issued < exp_len);
      bus.wr_data_req_i = cur;
      #1;
      total++;
      if (bus.wr_data_vld_o !== prev) begin
        bad++;
        $display("FAIL data_vld: got %b want %b", bus.wr_data_vld_o, prev);
      end
      if (bus.wr_data_vld_o === 1'b1) begin
        total++;
        if (exp_words.size() == 0) begin
          bad++;
          $display("FAIL data_word: got %h want none", bus.wr_data_o);
        end else begin
          w = exp_words.pop_front();
          if (bus.wr_data_o !== w) begin
            bad++;
            $display("FAIL data_word: got %h want %h", bus.wr_data_o, w);
          end
        end
      end
      total++;
      if (bus.fifo_rd_en_o !== pop_exp) begin
        bad++;
        $display("FAIL fifo_pop: got %b want %b (issued %0d of %0d)", bus.fifo_rd_en_o,
                 pop_exp, issued, exp_len);
      end
      if (pop_exp) issued++;
      prev = pop_exp;
    end
    @(negedge clk);
    bus.wr_data_req_i = 1'b0;
    #1;
    while (busy !== 1'b0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_end: busy_o=%b want 0", busy);
    end
    err_model = err_model | extra_req;
    total++;
    if (err !== err_model) begin
      bad++;
      $display("FAIL err_flag: got %b want %b", err, err_model);
    end
    advance(exp_len);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_enable = 1'b1;
    bus.wr_ack_i = 1'b0;
    bus.wr_data_req_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, err, bus.wr_req_o, bus.fifo_rd_en_o, bus.wr_data_vld_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: busy/err/req/pop/vld=%b want 00000",
               {busy, err, bus.wr_req_o, bus.fifo_rd_en_o, bus.wr_data_vld_o});
    end
    total++;
    if (bus.wr_addr_o !== '0 || bus.wr_len_o !== '0 || bus.wr_data_o !== '0) begin
      bad++;
      $display("FAIL reset_bus: addr=%h len=%0d data=%h want 0", bus.wr_addr_o,
               bus.wr_len_o, bus.wr_data_o);
    end
    bus.wr_data_req_i = 1'b0;
    do_reset(0, 'hFFF);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b err=%b want 0 0", busy, err);
    end
  endtask

  task automatic test_single_burst();
    do_reset(0, 'hFFF);
    wr_enable = 1'b1;
    push_words(8);
    serve_burst(2, 1'b0, 8, 1'b0);
    push_words(8);
    serve_burst(2, 1'b0, 8, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset(0, 'hB);
    wr_enable = 1'b1;
    push_words(20);
    while (fifo_cnt >= len_full()) serve_burst(1, 1'b0, len_full(), 1'b0);
  endtask

  task automatic test_flush();
    do_reset('h100, 'hFFF);
    wr_enable = 1'b1;
    push_words(3);
    repeat (6) @(negedge clk);
    #1;
    total++;
    if (bus.wr_req_o !== 1'b0) begin
      bad++;
      $display("FAIL partial_no_req: wr_req_o=%b want 0", bus.wr_req_o);
    end
    pulse_flush();
    serve_burst(1, 1'b0, (fifo_cnt < len_full()) ? fifo_cnt : len_full(), 1'b0);
    pulse_flush();
    repeat (6) @(negedge clk);
    #1;
    total++;
    if (bus.wr_req_o !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL empty_flush: req=%b busy=%b want 0 0", bus.wr_req_o, busy);
    end
    push_words(2);
    serve_burst(1, 1'b0, (fifo_cnt < len_full()) ? fifo_cnt : len_full(), 1'b0);
  endtask

  task automatic test_gapped();
    do_reset('h40, 'hFFF);
    wr_enable = 1'b1;
    push_words(24);
    for (int i = 0; i < 3; i++) serve_burst(int'($urandom_range(0, 3)), 1'b1, len_full(), 1'b0);
  endtask

  task automatic test_extra_req();
    do_reset(0, 'hFFF);
    wr_enable = 1'b1;
    push_words(8);
    serve_burst(1, 1'b0, 8, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err_o=%b want 1", err);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset(0, 'hFFF);
    wr_enable = 1'b1;
    push_words(16);
    wait_req(ok);
    wr_enable = 1'b0;
    serve_burst(1, 1'b1, 8, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (bus.wr_req_o !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL disabled_idle: req=%b busy=%b want 0 0", bus.wr_req_o, busy);
    end
    wr_enable = 1'b1;
    serve_burst(0, 1'b0, 8, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset(0, 'hFFF);
    wr_enable = 1'b1;
    push_words(8);
    wait_req(ok);
    bus.wr_ack_i = 1'b1;
    @(negedge clk);
    bus.wr_ack_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.wr_data_req_i = 1'b1;
    end
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || bus.fifo_rd_en_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_burst: busy=%b pop=%b want 1 1", busy, bus.fifo_rd_en_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.fifo_rd_en_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_pop_gate: fifo_rd_en_o=%b want 0", bus.fifo_rd_en_o);
    end
    @(negedge clk);
    #1;
    total++;
    if ({busy, bus.fifo_rd_en_o, bus.wr_req_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_abort: busy/pop/req=%b want 000",
               {busy, bus.fifo_rd_en_o, bus.wr_req_o});
    end
    bus.wr_data_req_i = 1'b0;
  endtask

  task automatic test_random();
    longint b, sz;
    for (int it = 0; it < 5; it++) begin
      b = longint'($urandom_range(0, 'hFFFF));
      sz = longint'($urandom_range(1, 20));
      do_reset(b, b + sz - 1);
      wr_enable = 1'b1;
      push_words(int'($urandom_range(1, 30)));
      while (fifo_cnt >= len_full())
        serve_burst(int'($urandom_range(0, 3)), 1'b1, len_full(), 1'b0);
      while (fifo_cnt > 0) begin
        pulse_flush();
        serve_burst(int'($urandom_range(0, 3)), 1'b1,
                    (fifo_cnt < len_full()) ? fifo_cnt : len_full(), 1'b0);
      end
    end
    total++;
    if (underflow != 0) begin
      bad++;
      $display("FAIL fifo_underflow: got %0d pops from empty FIFO, want 0", underflow);
    end
  endtask

  initial begin
    bus.wr_ack_i = 1'b0;
    bus.wr_data_req_i = 1'b0;
    bus.fifo_rd_data_i = '0;
    test_reset();
    test_single_burst();
    test_wrap();
    test_flush();
    test_gapped();
    test_extra_req();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_sdram_wr_burst_ctrl
